// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO helpers and parameter legality checks
package fifo_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit params_ok(input int width, input int depth_bit, input int af, input int ae);
    return width >= 1 && depth_bit >= 1 && af >= 1 && af <= (1 << depth_bit) &&
           ae >= 0 && ae < (1 << depth_bit);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port array, sync write, async or registered read
module fifo_ram import fifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int FWFT  = 1,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  // storage is never reset; only accepted writes land here
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // registered read port holds its last word between reads
  always_comb begin
    dout_d = re ? mem[raddr] : dout_q;
  end
  // read register clears on reset only
  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else dout_q <= dout_d;
  end
  assign rdata = (FWFT != 0) ? mem[raddr] : dout_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with FWFT/registered read, thresholds and sticky errors
module sync_fifo_ctrl import fifo_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_BIT = 5,
  parameter int AF_LEVEL  = 28,
  parameter int AE_LEVEL  = 4,
  parameter int FWFT      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   dati,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   dato,
  output logic               dato_vld,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [DEPTH_BIT:0] level,
  output logic               overflow,
  output logic               underflow
);
  localparam int LW = DEPTH_BIT + 1;
  if (!params_ok(WIDTH, DEPTH_BIT, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_ctrl: illegal parameter set");
  end
  logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic ovf_q, ovf_d, udf_q, udf_d, vld_q, vld_d, wr_acc, rd_acc;
  // pointers carry one extra bit, so their difference is the exact occupancy
  assign level        = wptr_q - rptr_q;
  assign full         = level == LW'(1 << DEPTH_BIT);
  assign empty        = level == '0;
  assign almost_full  = level >= LW'(AF_LEVEL);
  assign almost_empty = level <= LW'(AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign dato_vld     = (FWFT != 0) ? !empty : vld_q;
  // acceptance uses registered flags only; flush swallows requests and clears state
  always_comb begin
    wr_acc = wr_en && !full && !clr;
    rd_acc = rd_en && !empty && !clr;
    wptr_d = clr ? '0 : wptr_q + LW'(wr_acc);
    rptr_d = clr ? '0 : rptr_q + LW'(rd_acc);
    ovf_d  = !clr && (ovf_q || (wr_en && full));
    udf_d  = !clr && (udf_q || (rd_en && empty));
    vld_d  = rd_acc;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      vld_q  <= vld_d;
    end
  end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(1 << DEPTH_BIT), .FWFT(FWFT)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wptr_q[DEPTH_BIT-1:0]),
    .wdata (dati),
    .re    (rd_acc),
    .raddr (rptr_q[DEPTH_BIT-1:0]),
    .rdata (dato)
  );
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench driving an FWFT and a registered-read FIFO in lockstep
module tb_sync_fifo_ctrl;
  logic clk = 0, rst = 0, clr = 0, wr_en = 0, rd_en = 0;
  logic [7:0] dati = 0;
  logic [7:0] dato_f, dato_r;
  logic [3:0] level_f, level_r;
  logic vld_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic vld_r, full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  int n_cmp = 0, n_err = 0;
  int mlevel = 0;
  logic [7:0] q[$];
  logic [7:0] mlast = 0;
  logic movf = 0, mudf = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH_BIT(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .dati(dati), .rd_en(rd_en),
    .dato(dato_f), .dato_vld(vld_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .level(level_f), .overflow(ovf_f), .underflow(udf_f));

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH_BIT(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_rg (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .dati(dati), .rd_en(rd_en),
    .dato(dato_r), .dato_vld(vld_r), .full(full_r), .empty(empty_r), .almost_full(af_r),
    .almost_empty(ae_r), .level(level_r), .overflow(ovf_r), .underflow(udf_r));

  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rs);
    logic wa, ra;
    logic [7:0] exp;
    logic [10:0] est;
    wa = w && mlevel < 8 && !c && !rs;
    ra = r && mlevel > 0 && !c && !rs;
    rst = rs; clr = c; wr_en = w; rd_en = r; dati = d;
    #1;
    exp = mlast;
    if (ra) begin
      exp = q.pop_front();
      n_cmp++;
      if (dato_f !== exp) begin n_err++; $display("FAIL fwft_data: got %h want %h", dato_f, exp); end
    end
    if (wa) q.push_back(d);
    if (rs) begin
      mlevel = 0; q.delete(); movf = 0; mudf = 0; mlast = 0;
    end else if (c) begin
      mlevel = 0; q.delete(); movf = 0; mudf = 0;
    end else begin
      movf = movf || (w && mlevel == 8);
      mudf = mudf || (r && mlevel == 0);
      mlevel = mlevel + int'(wa) - int'(ra);
      if (ra) mlast = exp;
    end
    @(posedge clk);
    #1;
    rst = 0; clr = 0; wr_en = 0; rd_en = 0;
    est = {4'(mlevel), mlevel == 8, mlevel == 0, mlevel >= 6, mlevel <= 1, movf, mudf, mlevel != 0};
    n_cmp++;
    if ({level_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f, vld_f} !== est) begin
      n_err++;
      $display("FAIL fwft_status: got %b want %b", {level_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f, vld_f}, est);
    end
    est[0] = ra;
    n_cmp++;
    if ({level_r, full_r, empty_r, af_r, ae_r, ovf_r, udf_r, vld_r} !== est) begin
      n_err++;
      $display("FAIL reg_status: got %b want %b", {level_r, full_r, empty_r, af_r, ae_r, ovf_r, udf_r, vld_r}, est);
    end
    n_cmp++;
    if (dato_r !== mlast) begin n_err++; $display("FAIL reg_data: got %h want %h", dato_r, mlast); end
  endtask

  task automatic wr(input logic [7:0] d); cycle(1, d, 0, 0, 0); endtask
  task automatic rd(); cycle(0, 8'h00, 1, 0, 0); endtask

  task automatic test_reset();
    cycle(0, 8'h00, 0, 0, 1);
    n_cmp++;
    if (empty_f !== 1'b1 || dato_r !== 8'h00 || vld_r !== 1'b0) begin
      n_err++; $display("FAIL reset: got empty=%b dato=%h vld=%b want 1 00 0", empty_f, dato_r, vld_r);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) wr(8'(i));
    n_cmp++;
    if (full_f !== 1'b1 || level_f !== 4'd8) begin
      n_err++; $display("FAIL fill_full: got full=%b level=%0d want 1 8", full_f, level_f);
    end
    wr(8'hFF);
    n_cmp++;
    if (ovf_f !== 1'b1) begin n_err++; $display("FAIL overflow: got %b want 1", ovf_f); end
    for (int i = 0; i < 8; i++) rd();
    n_cmp++;
    if (empty_f !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty_f); end
  endtask

  task automatic test_underflow();
    rd();
    n_cmp++;
    if (udf_f !== 1'b1 || level_f !== 4'd0) begin
      n_err++; $display("FAIL underflow: got udf=%b level=%0d want 1 0", udf_f, level_f);
    end
    wr(8'h33);
    rd();
    cycle(0, 8'h00, 0, 1, 0);
    n_cmp++;
    if (ovf_f !== 1'b0 || udf_f !== 1'b0) begin
      n_err++; $display("FAIL clr_flags: got ovf=%b udf=%b want 0 0", ovf_f, udf_f);
    end
  endtask

  task automatic test_back_to_back();
    int v;
    v = 8'h40;
    for (int i = 0; i < 4; i++) begin wr(8'(v)); v++; end
    for (int i = 0; i < 28; i++) begin cycle(1, 8'(v), 1, 0, 0); v++; end
    n_cmp++;
    if (level_f !== 4'd4) begin n_err++; $display("FAIL steady_level: got %0d want 4", level_f); end
    for (int i = 0; i < 4; i++) rd();
  endtask

  task automatic test_full_both();
    cycle(0, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 8; i++) wr(8'(i));
    cycle(1, 8'hEE, 1, 0, 0);
    n_cmp++;
    if (level_f !== 4'd7 || ovf_f !== 1'b1) begin
      n_err++; $display("FAIL full_both: got level=%0d ovf=%b want 7 1", level_f, ovf_f);
    end
    for (int i = 0; i < 7; i++) rd();
    cycle(1, 8'h5A, 1, 0, 0);
    n_cmp++;
    if (level_f !== 4'd1 || udf_f !== 1'b1) begin
      n_err++; $display("FAIL empty_both: got level=%0d udf=%b want 1 1", level_f, udf_f);
    end
    rd();
  endtask

  task automatic test_registered();
    cycle(0, 8'h00, 0, 1, 0);
    wr(8'hA5);
    rd();
    n_cmp++;
    if (vld_r !== 1'b1 || dato_r !== 8'hA5) begin
      n_err++; $display("FAIL reg_read: got vld=%b dato=%h want 1 a5", vld_r, dato_r);
    end
    cycle(0, 8'h00, 0, 0, 0);
    n_cmp++;
    if (vld_r !== 1'b0 || dato_r !== 8'hA5) begin
      n_err++; $display("FAIL reg_hold: got vld=%b dato=%h want 0 a5", vld_r, dato_r);
    end
  endtask

  task automatic test_rst_mid();
    cycle(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    cycle(1, 8'h77, 0, 0, 1);
    n_cmp++;
    if (level_f !== 4'd0 || empty_f !== 1'b1 || dato_r !== 8'h00) begin
      n_err++; $display("FAIL rst_mid: got level=%0d empty=%b dato=%h want 0 1 00", level_f, empty_f, dato_r);
    end
    wr(8'h88);
    rd();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_full_both();
    test_registered();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
